// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver.
// Latches a BCD word plus per-digit decimal points into shadow registers, then
// scans one digit per slot with a short all-anodes-off guard at each slot start
// and optional leading-zero suppression. All board-facing outputs are registered.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_DIV     = 50000,
  parameter int BLANK_CYC   = 2,
  parameter int LZ_SUPPRESS = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_DIGITS - 1);

  logic [CW-1:0]                cnt;
  logic [PW-1:0]                ptr;
  logic [NUM_DIGITS-1:0][3:0]   bcd_sh;
  logic [NUM_DIGITS-1:0]        dp_sh;

  logic                         slot_end;
  logic                         frame_wrap;
  logic                         in_blank;
  logic [NUM_DIGITS-1:0]        lz_blank;
  logic [3:0]                   cur_digit;
  logic [6:0]                   cur_font;
  logic [7:0]                   seg_d;
  logic [NUM_DIGITS-1:0]        an_d;

  // Active-high A..G pattern for one code; A-E are blank, F is a dash.
  function automatic logic [6:0] font(input logic [3:0] code);
    logic [6:0] f;
    case (code)
      4'h0:    f = 7'h3F;
      4'h1:    f = 7'h06;
      4'h2:    f = 7'h5B;
      4'h3:    f = 7'h4F;
      4'h4:    f = 7'h66;
      4'h5:    f = 7'h6D;
      4'h6:    f = 7'h7D;
      4'h7:    f = 7'h07;
      4'h8:    f = 7'h7F;
      4'h9:    f = 7'h6F;
      4'hF:    f = 7'h40;
      default: f = 7'h00;
    endcase
    return f;
  endfunction

  assign slot_end   = (cnt == CNT_LAST);
  assign frame_wrap = slot_end && (ptr == PTR_LAST);

  // Ghost guard window: the first BLANK_CYC cycles of every digit slot.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CW'(BLANK_CYC));
    end
  endgenerate

  // Leading-zero map: a digit above 0 blanks when it and every higher digit are zero.
  always_comb begin
    logic higher_zero;
    // NOTE: blocking assignments here are intentional; higher_zero is a running
    // value carried down the loop, and every output gets a default first so no latch forms.
    higher_zero = 1'b1;
    lz_blank    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (bcd_sh[i] == 4'd0);
      if ((i > 0) && (LZ_SUPPRESS != 0)) lz_blank[i] = higher_zero;
    end
  end

  // Next segment/anode pattern for the digit currently under the pointer.
  always_comb begin
    cur_digit = bcd_sh[ptr];
    cur_font  = lz_blank[ptr] ? 7'h00 : font(cur_digit);
    seg_d     = 8'hFF;
    an_d      = '1;
    if (!in_blank) begin
      an_d[ptr] = 1'b0;
      seg_d     = {~dp_sh[ptr], ~cur_font};
    end
  end

  // Prescaler and digit pointer; the pointer advances once per slot.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ptr <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers for the displayed word; only load updates them.
  // NOTE: the shadow is reset (not left to power-up) so digit 0 shows a clean '0'
  // straight out of reset instead of random segments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_sh <= '0;
      dp_sh  <= '0;
    end else if (load) begin
      bcd_sh <= bcd_in;
      dp_sh  <= dp_in;
    end
  end

  // Registered pin drivers and frame pulse, one cycle behind the scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= 8'hFF;
      an         <= '1;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_d;
      an         <= an_d;
      frame_tick <= frame_wrap;
    end
  end

endmodule
